pulse_width_meter: RTL and testbench

//  Multi-channel echo pulse-width meter for ultrasonic rangers (HC-SR04 class) on DE0-CV.

---
 rtl/pulse_width_meter_pkg.sv | 22 ++
 rtl/pulse_width_meter_if.sv | 26 ++
 rtl/pulse_width_channel.sv | 123 ++++++++++++
 rtl/pulse_width_meter.sv | 75 +++++++
 tb/tb_pulse_width_meter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pulse_width_meter_pkg.sv
// Shared definitions for the pulse-width meter.
//   - Channel FSM state encodings (2-bit constants, legacy-compatible).
//   - Default timing constants for a 50 MHz CLOCK_50.
//   - cnt_width(): number of bits needed to hold the values 0..max_val.
package pulse_width_meter_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd1;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd2;
  localparam logic [1:0] ST_MEASURE   = 2'd3;

  localparam int DEF_N_CH           = 2;
  localparam int DEF_W              = 24;
  localparam int DEF_TRIG_CYCLES    = 500;        // 10 us
  localparam int DEF_PERIOD_CYCLES  = 3_000_000;  // 60 ms
  localparam int DEF_TIMEOUT_CYCLES = 2_000_000;  // 40 ms

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulse_width_meter_if.sv
// Bus between the pulse-width meter and the board glue.
//   enable    : run trigger and measurement
//   echo_i    : raw asynchronous echo inputs, one bit per channel
//   trig_o    : trigger to all sensors
//   width_o   : last result per channel, channel k at [k*W +: W]
//   valid_o   : one-cycle strobe per channel, width_o[k] updated
//   timeout_o : per channel, last result was a timeout
//   busy_o    : any channel measuring
// master = board glue side, slave = meter side.
interface pulse_width_meter_if #(
  parameter int N_CH = 2,
  parameter int W    = 24
);
  logic              enable;
  logic [N_CH-1:0]   echo_i;
  logic              trig_o;
  logic [N_CH*W-1:0] width_o;
  logic [N_CH-1:0]   valid_o;
  logic [N_CH-1:0]   timeout_o;
  logic              busy_o;

  modport master (output enable, echo_i,
                  input  trig_o, width_o, valid_o, timeout_o, busy_o);
  modport slave  (input  enable, echo_i,
                  output trig_o, width_o, valid_o, timeout_o, busy_o);
endinterface

// File: rtl/pulse_width_channel.sv
// One echo channel: 2-FF synchroniser, edge detect, FSM, saturating width
// counter, timeout counter and result register.
//   CLOCK_50, RESET_N : clock, async active-low reset
//   enable            : 0 forces IDLE (results hold, no strobe)
//   arm               : one-cycle start pulse from the trigger generator
//   echo_i            : raw asynchronous echo
//   width_o           : last result (all ones on timeout)
//   valid_o           : one-cycle strobe when width_o/timeout_o update
//   timeout_o         : last result was a timeout
//   busy_o            : FSM not IDLE
module pulse_width_channel
  import pulse_width_meter_pkg::*;
#(
  parameter int W              = DEF_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic         enable,
  input  logic         arm,
  input  logic         echo_i,
  output logic [W-1:0] width_o,
  output logic         valid_o,
  output logic         timeout_o,
  output logic         busy_o
);

  // Timeout counter is sized from its own limit, independent of W.
  localparam int              TW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [W-1:0]    W_MAX    = '1;

  logic          sync1_q, sync2_q, echo_d_q;
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  wcnt_q, wcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [W-1:0]  width_q, width_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          s, rise, fall, to_hit;

  assign s    = sync2_q;
  assign rise = s & ~echo_d_q;
  assign fall = ~s & echo_d_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = tcnt_q;
    width_d   = width_q;
    timeout_d = timeout_q;
    valid_d   = 1'b0;
    // tcnt_q stays below TO_LIMIT while armed, so the increment cannot wrap.
    tcnt_inc  = tcnt_q + 1'b1;
    to_hit    = (tcnt_inc == TO_LIMIT);

    if (!enable) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      // Arming from any state restarts cleanly; an in-flight measurement is
      // dropped without a strobe.
      state_d = s ? ST_WAIT_LOW : ST_WAIT_HIGH;
      tcnt_d  = '0;
    end else if (state_q != ST_IDLE) begin
      tcnt_d = tcnt_inc;
      case (state_q)
        ST_WAIT_LOW:  if (!s) state_d = ST_WAIT_HIGH;
        ST_WAIT_HIGH: if (rise) begin
                        state_d = ST_MEASURE;
                        wcnt_d  = W'(1);
                      end
        ST_MEASURE:   if (s && (wcnt_q != W_MAX)) wcnt_d = wcnt_q + 1'b1;
        default:      ;
      endcase
      // A fall on the timeout cycle still yields a normal result.
      if ((state_q == ST_MEASURE) && fall) begin
        width_d   = wcnt_q;
        timeout_d = 1'b0;
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end else if (to_hit) begin
        width_d   = W_MAX;
        timeout_d = 1'b1;
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      echo_d_q  <= 1'b0;
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      width_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync1_q   <= echo_i;
      sync2_q   <= sync1_q;
      echo_d_q  <= sync2_q;
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      tcnt_q    <= tcnt_d;
      width_q   <= width_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign width_o   = width_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: rtl/pulse_width_meter.sv
// Multi-channel ultrasonic echo pulse-width meter.
// Generates a periodic trigger and measures each echo's high time in clocks.
//   CLOCK_50 : 50 MHz system clock
//   RESET_N  : async active-low reset
//   bus      : slave side of pulse_width_meter_if (enable, echo_i in;
//              trig_o, width_o, valid_o, timeout_o, busy_o out)
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int W              = DEF_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  pulse_width_meter_if.slave   bus
);

  localparam int            PW       = cnt_width(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] CNT_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] CNT_TRIG = PW'(TRIG_CYCLES);

  logic [PW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;
  logic            trig_q, trig_d;
  logic            arm;
  logic [N_CH-1:0] ch_busy;

  // run_q marks the first enabled cycle so the period restarts at count 0
  // and trig_q equals (run_q && cnt_q < TRIG_CYCLES) without a glitchy path.
  always_comb begin
    run_d = bus.enable;
    cnt_d = '0;
    if (bus.enable && run_q) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    trig_d = bus.enable && (cnt_d < CNT_TRIG);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      trig_q <= trig_d;
    end
  end

  // Arm on the trigger's falling edge.
  assign arm = run_q && (cnt_q == CNT_TRIG);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pulse_width_channel #(
      .W              (W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ch (
      .CLOCK_50  (CLOCK_50),
      .RESET_N   (RESET_N),
      .enable    (bus.enable),
      .arm       (arm),
      .echo_i    (bus.echo_i[k]),
      .width_o   (bus.width_o[k*W +: W]),
      .valid_o   (bus.valid_o[k]),
      .timeout_o (bus.timeout_o[k]),
      .busy_o    (ch_busy[k])
    );
  end

  assign bus.trig_o = trig_q;
  assign bus.busy_o = |ch_busy;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter.
// u_dut: N_CH=2, W=8, TRIG=4, PERIOD=100, TIMEOUT=60.
// u_sat: N_CH=1, W=4, same timing, for width saturation.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pulse_width_meter;

  logic CLOCK_50 = 1'b0;
  logic RESET_N;
  always #5 CLOCK_50 = ~CLOCK_50;

  pulse_width_meter_if #(.N_CH(2), .W(8)) bus ();
  pulse_width_meter_if #(.N_CH(1), .W(4)) bus_s ();

  pulse_width_meter #(
    .N_CH(2), .W(8), .TRIG_CYCLES(4), .PERIOD_CYCLES(100), .TIMEOUT_CYCLES(60)
  ) u_dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  pulse_width_meter #(
    .N_CH(1), .W(4), .TRIG_CYCLES(4), .PERIOD_CYCLES(100), .TIMEOUT_CYCLES(60)
  ) u_sat (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus_s)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Free-running cycle count (advances on posedge, read on negedge) and
  // per-channel valid pulse counters.
  int cyc = 0;
  int nv0 = 0, nv1 = 0, nvs = 0;
  int v1_cyc = 0;
  int arm_cyc = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (bus.valid_o[0]) nv0++;
    if (bus.valid_o[1]) begin nv1++; v1_cyc = cyc; end
    if (bus_s.valid_o[0]) nvs++;
  end

  // Return on the falling edge of the first cycle with trig_o low after it
  // was high: that is the arm cycle (count == 4).
  task automatic wait_arm();
    logic prev;
    prev = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge CLOCK_50);
      if (prev && !bus.trig_o) begin
        arm_cyc = cyc;
        return;
      end
      prev = bus.trig_o;
    end
    check("arm_seen", 32'd0, 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, s0, s1, ss;

    RESET_N         = 1'b0;
    bus.enable      = 1'b0;
    bus.echo_i      = '0;
    bus_s.enable    = 1'b0;
    bus_s.echo_i    = '0;

    // Reset state
    tick(3);
    check("rst_trig",    32'(bus.trig_o),    32'd0);
    check("rst_width",   32'(bus.width_o),   32'd0);
    check("rst_valid",   32'(bus.valid_o),   32'd0);
    check("rst_timeout", 32'(bus.timeout_o), 32'd0);
    check("rst_busy",    32'(bus.busy_o),    32'd0);

    RESET_N      = 1'b1;
    bus.enable   = 1'b1;
    bus_s.enable = 1'b1;

    // 1. Trigger: high 4 cycles, low 96 cycles per 100-cycle period.
    hi = 0; lo = 0;
    for (int i = 0; i < 200 && !bus.trig_o; i++) @(negedge CLOCK_50);
    while (bus.trig_o && hi < 200) begin hi++; @(negedge CLOCK_50); end
    while (!bus.trig_o && lo < 200) begin lo++; @(negedge CLOCK_50); end
    check("trig_high_cycles", 32'(hi), 32'd4);
    check("trig_low_cycles",  32'(lo), 32'd96);

    // 2/3/5. ch0 echo high 20 clocks; ch1 silent; W=4 instance echo 20 clocks.
    wait_arm();
    s0 = nv0; s1 = nv1; ss = nvs;
    tick(3);
    bus.echo_i[0]   = 1'b1;
    bus_s.echo_i[0] = 1'b1;
    tick(20);
    bus.echo_i[0]   = 1'b0;
    bus_s.echo_i[0] = 1'b0;
    tick(67);
    check("ch0_width20",     32'(bus.width_o[7:0]),  32'd20);
    check("ch0_timeout0",    32'(bus.timeout_o[0]),  32'd0);
    check("ch0_valid_count", 32'(nv0 - s0),          32'd1);
    check("ch1_width_ff",    32'(bus.width_o[15:8]), 32'hFF);
    check("ch1_timeout1",    32'(bus.timeout_o[1]),  32'd1);
    check("ch1_valid_count", 32'(nv1 - s1),          32'd1);
    // valid rises on the 60th clock edge after the edge that samples arm,
    // i.e. 61 rising edges after the arm cycle's falling edge.
    check("ch1_timeout_lat", 32'(v1_cyc - arm_cyc),  32'd61);
    check("sat_width_f",     32'(bus_s.width_o),     32'hF);
    check("sat_timeout0",    32'(bus_s.timeout_o),   32'd0);
    check("sat_valid_count", 32'(nvs - ss),          32'd1);

    // 4. ch0 stale high at arm, falls, then high 10 clocks.
    bus.echo_i[0] = 1'b1;
    wait_arm();
    s0 = nv0;
    tick(5);
    bus.echo_i[0] = 1'b0;
    tick(5);
    bus.echo_i[0] = 1'b1;
    tick(10);
    bus.echo_i[0] = 1'b0;
    tick(60);
    check("stale_width10",     32'(bus.width_o[7:0]), 32'd10);
    check("stale_timeout0",    32'(bus.timeout_o[0]), 32'd0);
    check("stale_valid_count", 32'(nv0 - s0),         32'd1);

    // 6a. enable=0 mid-MEASURE.
    wait_arm();
    s0 = nv0; s1 = nv1;
    tick(3);
    bus.echo_i[0] = 1'b1;
    tick(8);
    check("abort_busy_before", 32'(bus.busy_o), 32'd1);
    bus.enable = 1'b0;
    tick(1);
    check("abort_busy_after", 32'(bus.busy_o), 32'd0);
    check("abort_trig",       32'(bus.trig_o), 32'd0);
    bus.echo_i[0] = 1'b0;
    tick(10);
    check("abort_no_valid0",   32'(nv0 - s0),          32'd0);
    check("abort_no_valid1",   32'(nv1 - s1),          32'd0);
    check("abort_width0_hold", 32'(bus.width_o[7:0]),  32'd10);
    check("abort_to0_hold",    32'(bus.timeout_o[0]),  32'd0);
    check("abort_width1_hold", 32'(bus.width_o[15:8]), 32'hFF);
    check("abort_to1_hold",    32'(bus.timeout_o[1]),  32'd1);

    // 6b. Async reset mid-MEASURE.
    bus.enable = 1'b1;
    wait_arm();
    tick(3);
    bus.echo_i[0] = 1'b1;
    tick(8);
    check("rst_mid_busy_before", 32'(bus.busy_o), 32'd1);
    #1 RESET_N = 1'b0;
    #1;
    check("rst_mid_width",     32'(bus.width_o),     32'd0);
    check("rst_mid_valid",     32'(bus.valid_o),     32'd0);
    check("rst_mid_timeout",   32'(bus.timeout_o),   32'd0);
    check("rst_mid_busy",      32'(bus.busy_o),      32'd0);
    check("rst_mid_trig",      32'(bus.trig_o),      32'd0);
    check("rst_mid_sat_width", 32'(bus_s.width_o),   32'd0);
    check("rst_mid_sat_to",    32'(bus_s.timeout_o), 32'd0);
    bus.echo_i = '0;
    tick(2);
    RESET_N = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
